// File: rtl/hack_mul_ctrl_pkg.sv
// Shared Hack definitions: ALU comp control words and the multiply sequencer state encoding.
package hack_mul_ctrl_pkg;

    // Control word order is {zx, nx, zy, ny, f, no}.
    localparam logic [5:0] ALU_ZERO    = 6'b101010;
    localparam logic [5:0] ALU_ONE     = 6'b111111;
    localparam logic [5:0] ALU_NEG_ONE = 6'b111010;
    localparam logic [5:0] ALU_X       = 6'b001100;
    localparam logic [5:0] ALU_Y       = 6'b110000;
    localparam logic [5:0] ALU_NOT_X   = 6'b001101;
    localparam logic [5:0] ALU_NOT_Y   = 6'b110001;
    localparam logic [5:0] ALU_NEG_X   = 6'b001111;
    localparam logic [5:0] ALU_NEG_Y   = 6'b110011;
    localparam logic [5:0] ALU_XPLUS1  = 6'b011111;
    localparam logic [5:0] ALU_YPLUS1  = 6'b110111;
    localparam logic [5:0] ALU_XMINUS1 = 6'b001110;
    localparam logic [5:0] ALU_YMINUS1 = 6'b110010;
    localparam logic [5:0] ALU_XPLUSY  = 6'b000010;
    localparam logic [5:0] ALU_XMINUSY = 6'b010011;
    localparam logic [5:0] ALU_YMINUSX = 6'b000111;
    localparam logic [5:0] ALU_XANDY   = 6'b000000;
    localparam logic [5:0] ALU_XORY    = 6'b010101;

    localparam int unsigned Width = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDbl  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/hack_mul_ctrl_if.sv
// Request/result bundle between a Hack CPU-side master and the multiply sequencer.
interface hack_mul_ctrl_if;
    import hack_mul_ctrl_pkg::*;

    logic             start;
    logic [Width-1:0] a;
    logic [Width-1:0] b;
    logic             busy;
    logic             done;
    logic [Width-1:0] product;
    logic             product_zr;
    logic             product_ng;

    modport master (
        output start, a, b,
        input  busy, done, product, product_zr, product_ng
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, product_zr, product_ng
    );

endinterface

// File: rtl/hack_mul_ctrl_alu.sv
// Hack ALU: purely combinational, operation selected by the six-bit comp control word.
module hack_mul_ctrl_alu
    import hack_mul_ctrl_pkg::*;
(
    input  logic [Width-1:0] x_i,
    input  logic [Width-1:0] y_i,
    input  logic [5:0]       ctrl_i,
    output logic [Width-1:0] out_o
);

    logic [Width-1:0] x_z, x_n, y_z, y_n, f_out;

    always_comb begin
        x_z   = ctrl_i[5] ? '0 : x_i;
        x_n   = ctrl_i[4] ? ~x_z : x_z;
        y_z   = ctrl_i[3] ? '0 : y_i;
        y_n   = ctrl_i[2] ? ~y_z : y_z;
        f_out = ctrl_i[1] ? (x_n + y_n) : (x_n & y_n);
        out_o = ctrl_i[0] ? ~f_out : f_out;
    end

endmodule

// File: rtl/hack_mul_ctrl.sv
// Shift-and-add 16-bit multiply sequencer; every addition goes through one Hack ALU in x+y mode.
module hack_mul_ctrl
    import hack_mul_ctrl_pkg::*;
(
    input logic           clk,
    input logic           reset,
    hack_mul_ctrl_if.slave bus
);

    state_e           state_q;
    logic [Width-1:0] acc_q, addend_q, mult_q;
    logic             busy_q, done_q;
    logic [Width-1:0] alu_x, alu_out;

    // ADD accumulates acc+addend; DBL reuses the same adder as addend+addend.
    always_comb begin
        alu_x = (state_q == StAdd) ? acc_q : addend_q;
    end

    hack_mul_ctrl_alu u_alu (
        .x_i   (alu_x),
        .y_i   (addend_q),
        .ctrl_i(ALU_XPLUSY),
        .out_o (alu_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            addend_q <= '0;
            mult_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        acc_q    <= '0;
                        addend_q <= bus.a;
                        mult_q   <= bus.b;
                        busy_q   <= 1'b1;
                        if (bus.b == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StAdd;
                        end
                    end
                end
                StAdd: begin
                    if (mult_q[0]) begin
                        acc_q <= alu_out;
                    end
                    state_q <= StDbl;
                end
                StDbl: begin
                    addend_q <= alu_out;
                    mult_q   <= mult_q >> 1;
                    // No multiplier bits left above the one just consumed: result is final.
                    if (mult_q[Width-1:1] == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StAdd;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.product    = acc_q;
    assign bus.product_zr = (acc_q == '0);
    assign bus.product_ng = acc_q[Width-1];

endmodule

// File: tb/tb_hack_mul_ctrl.sv
// Self-checking bench for hack_mul_ctrl: directed vector table, corner sequences, random ops.
module tb_hack_mul_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hack_mul_ctrl_if bus ();

    hack_mul_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] prod;
        int          lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: low 16 bits of a*b; latency 1 for b==0, else 2*(msb_index+1)+1.
    function automatic int model_lat(input logic [15:0] b);
        int k;
        k = -1;
        for (int i = 0; i < 16; i++) if (b[i]) k = i;
        return (k < 0) ? 1 : 2 * (k + 1) + 1;
    endfunction

    function automatic logic [15:0] model_prod(input logic [15:0] a, input logic [15:0] b);
        int unsigned p;
        p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    // Starts an op so it is accepted at edge 0 and samples each following cycle #1 after the edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_prod, input int exp_lat, input string tag);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'hdead;
        bus.b     = 16'hbeef;
        cyc = 1;
        check({tag, " busy_c1"}, 32'(bus.busy), 32'd1);
        while (!bus.done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " done_cycle"}, 32'(cyc), 32'(exp_lat));
        check({tag, " product"}, 32'(bus.product), 32'(exp_prod));
        check({tag, " zr"}, 32'(bus.product_zr), 32'(exp_prod == 16'h0));
        check({tag, " ng"}, 32'(bus.product_ng), 32'(exp_prod[15]));
        @(posedge clk);
        #1;
        check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, " done_after"}, 32'(bus.done), 32'd0);
        check({tag, " product_held"}, 32'(bus.product), 32'(exp_prod));
    endtask

    initial begin
        logic        seen_done;
        logic [15:0] ra, rb;

        vecs[0] = '{a: 16'h0011, b: 16'd3,    prod: 16'h0033, lat: 5};
        vecs[1] = '{a: 16'hFFFF, b: 16'd3,    prod: 16'hFFFD, lat: 5};
        vecs[2] = '{a: 16'h0100, b: 16'h0100, prod: 16'h0000, lat: 19};
        vecs[3] = '{a: 16'h1234, b: 16'h0000, prod: 16'h0000, lat: 1};
        vecs[4] = '{a: 16'hFFFF, b: 16'hFFFF, prod: 16'h0001, lat: 33};

        // Reset together with start: reset must win.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 16'h0005;
        bus.b     = 16'h0003;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset product", 32'(bus.product), 32'd0);
        check("reset zr", 32'(bus.product_zr), 32'd1);
        check("reset ng", 32'(bus.product_ng), 32'd0);
        bus.start = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        check("idle after reset busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Mid-operation: ignored start at cycle 2, reset at cycle 3.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'd5;
        bus.b     = 16'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen_done = bus.done;
        @(posedge clk);
        #1;
        seen_done |= bus.done;
        bus.start = 1'b1;
        bus.a     = 16'd9;
        bus.b     = 16'd9;
        @(posedge clk);
        #1;
        seen_done |= bus.done;
        bus.start = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset product", 32'(bus.product), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            seen_done |= bus.done;
            check("midreset stays idle", 32'(bus.busy), 32'd0);
        end
        check("midreset no done pulse", 32'(seen_done), 32'd0);
        run_op(16'd5, 16'd7, 16'd35, 7, "fresh");

        // start held high: accepted again every IDLE cycle, 6-cycle cadence for b=2.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'd2;
        bus.b     = 16'd2;
        @(posedge clk);
        for (int c = 1; c <= 18; c++) begin
            #1;
            check($sformatf("hold done c%0d", c), 32'(bus.done),
                  32'(c == 5 || c == 11 || c == 17));
            if (c == 5 || c == 11 || c == 17) check("hold product", 32'(bus.product), 32'd4);
            @(posedge clk);
        end
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("hold drained", 32'(bus.busy), 32'd0);

        // Random operands with a spread of multiplier widths.
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 16);
            run_op(ra, rb, model_prod(ra, rb), model_lat(rb), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
